// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, then start/data/parity/stop on device clock edges.
// Optional ack check and tx_err reporting are built when PS2_TX_ACK_EN is defined.
module ps2_host_tx #(
    parameter int RTS_CYCLES = 13000,
    parameter int FILT_LEN   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err
);

    localparam int CNT_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RTS_CYCLES - 1);

`ifdef PS2_TX_ACK_EN
    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK} state_t;
`else
    typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP} state_t;
`endif

    state_t              state_reg, state_next;
    logic [8:0]          b_reg, b_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [3:0]          n_reg, n_next;
    logic [FILT_LEN-1:0] filt_reg, filt_next;
    logic                ps2c_f_reg, ps2c_f_next;
    logic                done_reg, done_next;
    logic                fall_edge;

    // ps2c_f only moves once FILT_LEN consecutive samples agree
    always_comb begin
        filt_next = {ps2c_in, filt_reg[FILT_LEN-1:1]};
        if (&filt_next)
            ps2c_f_next = 1'b1;
        else if (~|filt_next)
            ps2c_f_next = 1'b0;
        else
            ps2c_f_next = ps2c_f_reg;
    end

    assign fall_edge = ps2c_f_reg & ~ps2c_f_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            b_reg      <= '0;
            cnt_reg    <= '0;
            n_reg      <= '0;
            filt_reg   <= '0;
            ps2c_f_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            b_reg      <= b_next;
            cnt_reg    <= cnt_next;
            n_reg      <= n_next;
            filt_reg   <= filt_next;
            ps2c_f_reg <= ps2c_f_next;
            done_reg   <= done_next;
        end
    end

`ifdef PS2_TX_ACK_EN
    logic err_reg, err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_reg <= 1'b0;
        else
            err_reg <= err_next;
    end

    assign tx_err = err_reg;
`else
    logic unused_ps2d;

    assign unused_ps2d = ps2d_in;
    assign tx_err      = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        b_next     = b_reg;
        cnt_next   = cnt_reg;
        n_next     = n_reg;
        ps2c_oe    = 1'b0;
        ps2d_oe    = 1'b0;
        tx_idle    = 1'b0;
`ifdef PS2_TX_ACK_EN
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                tx_idle = 1'b1;
                if (wr_ps2) begin
                    b_next     = {~^din, din};
                    cnt_next   = CNT_LOAD;
                    state_next = RTS;
`ifdef PS2_TX_ACK_EN
                    err_next   = 1'b0;
`endif
                end
            end
            RTS: begin
                ps2c_oe = 1'b1;
                if (cnt_reg == '0)
                    state_next = START;
                else
                    cnt_next = cnt_reg - 1'b1;
            end
            START: begin
                ps2d_oe = 1'b1;
                if (fall_edge) begin
                    n_next     = 4'd8;
                    state_next = DATA;
                end
            end
            DATA: begin
                ps2d_oe = ~b_reg[0];
                if (fall_edge) begin
                    b_next = {1'b0, b_reg[8:1]};
                    if (n_reg == 4'd0)
                        state_next = STOP;
                    else
                        n_next = n_reg - 4'd1;
                end
            end
            STOP: begin
                if (fall_edge) begin
`ifdef PS2_TX_ACK_EN
                    err_next   = ps2d_in;
                    state_next = ACK;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef PS2_TX_ACK_EN
            ACK: begin
                if (ps2c_f_reg && ps2d_in)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
        // done pulse lands on the first cycle back in IDLE
        done_next = (state_next == IDLE) && (state_reg != IDLE);
    end

    assign tx_done_tick = done_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Expected frame bits come from the byte value: start 0, data LSB first, odd parity, stop 1.
module tb_ps2_host_tx;

    localparam int RTS = 40;
    localparam int FILT = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in, ps2d_in;
    logic       ps2c_oe, ps2d_oe;
    logic       tx_idle, tx_done_tick, tx_err;
    logic       dev_clk, dev_data;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    assign ps2c_in = ps2c_oe ? 1'b0 : dev_clk;
    assign ps2d_in = ps2d_oe ? 1'b0 : dev_data;

    ps2_host_tx #(.RTS_CYCLES(RTS), .FILT_LEN(FILT)) dut (
        .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
        .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .tx_idle(tx_idle), .tx_done_tick(tx_done_tick), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (tx_done_tick) done_cnt <= done_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One device clock pulse: high phase (data sampled at its end), then a falling edge and low phase
    task automatic devPulse(input bit glitch, input bit ack, input bit extra_wr, output logic sampled);
        repeat (6) @(negedge clk);
        if (glitch) begin
            dev_clk = 1'b0;
            repeat (3) @(negedge clk);
            dev_clk = 1'b1;
        end else begin
            repeat (3) @(negedge clk);
        end
        if (extra_wr) begin
            wr_ps2 = 1'b1;
            din = 8'($urandom);
        end
        @(negedge clk);
        wr_ps2 = 1'b0;
        repeat (10) @(negedge clk);
        sampled = ps2d_in;
        dev_clk = 1'b0;
        if (ack) dev_data = 1'b0;
        repeat (20) @(negedge clk);
        dev_clk = 1'b1;
        dev_data = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit glitch, input bit extra_wr, input bit ack);
        logic exp_bits [11];
        logic s;
        int rts_len, guard, done_start;
        logic exp_err;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1+i] = data[i];
        exp_bits[9] = ($countones(data) % 2 == 0) ? 1'b1 : 1'b0;
        exp_bits[10] = 1'b1;
`ifdef PS2_TX_ACK_EN
        exp_err = ~ack;
`else
        exp_err = 1'b0;
`endif
        done_start = done_cnt;
        @(negedge clk);
        din = data;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        rts_len = 0;
        guard = 0;
        while (ps2c_oe && guard < RTS * 4) begin
            rts_len++;
            guard++;
            @(negedge clk);
        end
        checkOutput("rts_len", rts_len, RTS);
        checkOutput("busy", {31'd0, tx_idle}, 0);
        for (int k = 0; k < 11; k++) begin
            devPulse(glitch && k >= 2 && k <= 9, ack && k == 10, extra_wr && k == 4, s);
            checkOutput($sformatf("bit%0d_of_%02h", k, data), {31'd0, s}, {31'd0, exp_bits[k]});
        end
        repeat (30) @(negedge clk);
        checkOutput("idle_after", {31'd0, tx_idle}, 1);
        checkOutput("done_ticks", done_cnt - done_start, 1);
        checkOutput("tx_err", {31'd0, tx_err}, {31'd0, exp_err});
    endtask

    initial begin
        logic s;
        int guard;
        reset = 1'b1;
        wr_ps2 = 1'b0;
        din = 8'h00;
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_ps2c_oe", {31'd0, ps2c_oe}, 0);
        checkOutput("rst_ps2d_oe", {31'd0, ps2d_oe}, 0);
        checkOutput("rst_idle", {31'd0, tx_idle}, 1);
        checkOutput("rst_done", {31'd0, tx_done_tick}, 0);
        checkOutput("rst_err", {31'd0, tx_err}, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        applyStimulus(8'hED, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h01, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1);

        // a device edge while idle must not start or disturb anything
        devPulse(1'b0, 1'b0, 1'b0, s);
        repeat (20) @(negedge clk);
        checkOutput("idle_edge_idle", {31'd0, tx_idle}, 1);
        checkOutput("idle_edge_oe", {30'd0, ps2c_oe, ps2d_oe}, 0);

        // reset in the middle of DATA releases both lines at once
        @(negedge clk);
        din = 8'h55;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        guard = 0;
        while (ps2c_oe && guard < RTS * 4) begin
            guard++;
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) devPulse(1'b0, 1'b0, 1'b0, s);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_ps2c_oe", {31'd0, ps2c_oe}, 0);
        checkOutput("midrst_ps2d_oe", {31'd0, ps2d_oe}, 0);
        checkOutput("midrst_idle", {31'd0, tx_idle}, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        applyStimulus(8'hC3, 1'b0, 1'b0, 1'b1);

        for (int r = 0; r < 8; r++)
            applyStimulus(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
